// File: rtl/dsp_pkg.sv
// Shared DSP package: sequencer state encoding, instruction format and default widths.
// Used by dsp_sequencer and the fetch interface.
package dsp_pkg;

  localparam int INSTR_ADDR_WIDTH_DEF  = 10;
  localparam int SAMPLE_ADDR_WIDTH_DEF = 10;
  localparam int PIPE_DEPTH_DEF        = 4;

  // PIPE_DEPTH is limited to 1..15, so a 4-bit drain counter always fits.
  localparam int DRAIN_CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_MAC   = 4'h3,
    OP_ADD   = 4'h4,
    OP_MUL   = 4'h5,
    OP_MOV   = 4'h6,
    OP_SAT   = 4'h7
  } opcode_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [3:0]  dst;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [15:0] imm;
  } instr_t;

  // Drain counter load value: counts PIPE_DEPTH cycles down to zero inclusive.
  function automatic logic [DRAIN_CNT_WIDTH-1:0] drain_load(input int depth);
    return DRAIN_CNT_WIDTH'(depth - 1);
  endfunction

endpackage

// File: rtl/dsp_sequencer_if.sv
// Instruction-fetch port between dsp_sequencer (master) and the DSP core fetch stage (slave).
interface dsp_sequencer_if
  import dsp_pkg::*;
#(
  parameter int INSTR_ADDR_WIDTH = INSTR_ADDR_WIDTH_DEF
);

  logic [INSTR_ADDR_WIDTH-1:0] instr_rd_addr;
  logic                        instr_rd_en;

  modport master (
    output instr_rd_addr,
    output instr_rd_en
  );

  modport slave (
    input instr_rd_addr,
    input instr_rd_en
  );

endinterface

// File: rtl/dsp_sequencer.sv
// Frame-synchronous program sequencer: per frame strobe, fetch prog_len instructions, drain the
// pipeline, pulse frame_done. Define DSP_SEQ_ROTATE_EN to build the rotating rot_base register.
module dsp_sequencer
  import dsp_pkg::*;
#(
  parameter int INSTR_ADDR_WIDTH  = INSTR_ADDR_WIDTH_DEF,
  parameter int SAMPLE_ADDR_WIDTH = SAMPLE_ADDR_WIDTH_DEF,
  parameter int PIPE_DEPTH        = PIPE_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         frame_strobe,
  input  logic [INSTR_ADDR_WIDTH-1:0]  prog_len,
  input  logic                         overrun_clr,
  dsp_sequencer_if.master              fetch,
  output logic [SAMPLE_ADDR_WIDTH-1:0] rot_base,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun
);

  localparam logic [DRAIN_CNT_WIDTH-1:0] DRAIN_LOAD = drain_load(PIPE_DEPTH);

  seq_state_t                  state;
  logic [INSTR_ADDR_WIDTH-1:0] pc;
  logic [INSTR_ADDR_WIDTH-1:0] len;
  logic [DRAIN_CNT_WIDTH-1:0]  drain_cnt;
  logic                        rd_en;

  // The PC register drives the fetch address directly, keeping the output registered.
  assign fetch.instr_rd_addr = pc;
  assign fetch.instr_rd_en   = rd_en;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pc         <= '0;
      len        <= '0;
      drain_cnt  <= '0;
      rd_en      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // A strobe while busy is dropped; its sticky flag beats a simultaneous clear.
      if (frame_strobe && (state != IDLE)) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (frame_strobe) begin
            len  <= prog_len;
            pc   <= '0;
            busy <= 1'b1;
            if (prog_len != '0) begin
              state <= FETCH;
              rd_en <= 1'b1;
            end else begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end
        end

        FETCH: begin
          // PC holds on the last fetch, so it never wraps even at the maximum length.
          if (pc == len - INSTR_ADDR_WIDTH'(1)) begin
            state     <= DRAIN;
            rd_en     <= 1'b0;
            drain_cnt <= DRAIN_LOAD;
          end else begin
            pc <= pc + INSTR_ADDR_WIDTH'(1);
          end
        end

        DRAIN: begin
          if (drain_cnt == '0) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_CNT_WIDTH'(1);
          end
        end

        default: begin
          state <= IDLE;
          rd_en <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DSP_SEQ_ROTATE_EN
  // Steps on the same edge that raises frame_done, so both appear together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rot_base <= '0;
    end else if ((state == DRAIN) && (drain_cnt == '0)) begin
      rot_base <= rot_base - SAMPLE_ADDR_WIDTH'(1);
    end
  end
`else
  assign rot_base = '0;
`endif

endmodule

// File: tb/tb_dsp_sequencer.sv
// Directed self-checking bench for dsp_sequencer (PIPE_DEPTH = 4, 10-bit widths);
// rot_base expectations follow whether DSP_SEQ_ROTATE_EN is defined.
module tb_dsp_sequencer;

  localparam int IAW = 10;
  localparam int SAW = 10;
  localparam int P   = 4;

`ifdef DSP_SEQ_ROTATE_EN
  localparam bit ROT_ON = 1'b1;
`else
  localparam bit ROT_ON = 1'b0;
`endif

  logic           clk;
  logic           reset_n;
  logic           frame_strobe;
  logic [IAW-1:0] prog_len;
  logic           overrun_clr;
  logic [SAW-1:0] rot_base;
  logic           busy;
  logic           frame_done;
  logic           overrun;

  dsp_sequencer_if #(.INSTR_ADDR_WIDTH(IAW)) fetch_if ();

  dsp_sequencer #(
    .INSTR_ADDR_WIDTH (IAW),
    .SAMPLE_ADDR_WIDTH(SAW),
    .PIPE_DEPTH       (P)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_strobe(frame_strobe),
    .prog_len    (prog_len),
    .overrun_clr (overrun_clr),
    .fetch       (fetch_if.master),
    .rot_base    (rot_base),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int             n_checks = 0;
  int             n_pass   = 0;
  logic [SAW-1:0] exp_rot  = '0;
  logic           exp_ovr  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock and land 1 time unit after the edge, away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SAW-1:0] rot_after(input logic [SAW-1:0] cur);
    return ROT_ON ? cur - SAW'(1) : '0;
  endfunction

  // One full frame of length n, strobed in the current cycle; returns in the frame_done cycle.
  task automatic run_frame(input int n);
    logic [SAW-1:0] rot_next;
    rot_next     = rot_after(exp_rot);
    prog_len     = IAW'(n);
    frame_strobe = 1'b1;
    step();
    frame_strobe = 1'b0;
    for (int c = 1; c <= n + P + 1; c++) begin
      check($sformatf("rd_en len%0d c%0d", n, c), 32'(fetch_if.instr_rd_en), 32'(c <= n));
      if (c <= n)
        check($sformatf("rd_addr len%0d c%0d", n, c), 32'(fetch_if.instr_rd_addr), 32'(c - 1));
      check($sformatf("busy len%0d c%0d", n, c), 32'(busy), 32'(c <= n + P));
      check($sformatf("frame_done len%0d c%0d", n, c), 32'(frame_done), 32'(c == n + P + 1));
      check($sformatf("rot_base len%0d c%0d", n, c), 32'(rot_base),
            32'((c == n + P + 1) ? rot_next : exp_rot));
      check($sformatf("overrun len%0d c%0d", n, c), 32'(overrun), 32'(exp_ovr));
      if (c < n + P + 1) step();
    end
    exp_rot = rot_next;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rd_addr"}, 32'(fetch_if.instr_rd_addr), 32'd0);
    check({tag, " rd_en"}, 32'(fetch_if.instr_rd_en), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " frame_done"}, 32'(frame_done), 32'd0);
    check({tag, " overrun"}, 32'(overrun), 32'd0);
    check({tag, " rot_base"}, 32'(rot_base), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [SAW-1:0] rot_next;

    reset_n      = 1'b0;
    frame_strobe = 1'b0;
    prog_len     = '0;
    overrun_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check_all_zero("reset");

    // Basic frame, then a zero-length frame strobed in the frame_done cycle.
    run_frame(3);
    run_frame(0);

    // Back-to-back: second strobe lands on the frame_done cycle and is accepted.
    run_frame(2);
    run_frame(2);

    // Overrun: second strobe at cycle 4 of an 8-instruction frame.
    rot_next     = rot_after(exp_rot);
    prog_len     = IAW'(8);
    frame_strobe = 1'b1;
    step();
    frame_strobe = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      check($sformatf("ovr1 rd_en c%0d", c), 32'(fetch_if.instr_rd_en), 32'(c <= 8));
      if (c <= 8)
        check($sformatf("ovr1 rd_addr c%0d", c), 32'(fetch_if.instr_rd_addr), 32'(c - 1));
      check($sformatf("ovr1 overrun c%0d", c), 32'(overrun), 32'(c >= 5));
      check($sformatf("ovr1 frame_done c%0d", c), 32'(frame_done), 32'(c == 13));
      frame_strobe = (c == 4);
      if (c < 13) step();
    end
    check("ovr1 rot_base", 32'(rot_base), 32'(rot_next));
    exp_rot = rot_next;

    // Clear together with a busy strobe keeps overrun set; a lone clear later drops it.
    // prog_len changes mid-frame must not shorten the frame.
    rot_next     = rot_after(exp_rot);
    prog_len     = IAW'(8);
    frame_strobe = 1'b1;
    step();
    frame_strobe = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      check($sformatf("ovr2 rd_en c%0d", c), 32'(fetch_if.instr_rd_en), 32'(c <= 8));
      if (c <= 8)
        check($sformatf("ovr2 rd_addr c%0d", c), 32'(fetch_if.instr_rd_addr), 32'(c - 1));
      check($sformatf("ovr2 overrun c%0d", c), 32'(overrun), 32'(c <= 4));
      check($sformatf("ovr2 frame_done c%0d", c), 32'(frame_done), 32'(c == 13));
      frame_strobe = (c == 2);
      overrun_clr  = (c == 2) || (c == 4);
      if (c == 3) prog_len = IAW'(2);
      if (c < 13) step();
    end
    exp_rot = rot_next;
    exp_ovr = 1'b0;

    // Minimum and maximum program lengths.
    run_frame(1);
    run_frame((1 << IAW) - 1);

    // Reset asserted mid-frame, between clock edges.
    prog_len     = IAW'(10);
    frame_strobe = 1'b1;
    step();
    frame_strobe = 1'b0;
    repeat (4) step();
    check("rst rd_en c5", 32'(fetch_if.instr_rd_en), 32'd1);
    check("rst rd_addr c5", 32'(fetch_if.instr_rd_addr), 32'd4);
    #2 reset_n = 1'b0;
    #1 check_all_zero("rst async");
    exp_rot = '0;
    repeat (3) step();
    check_all_zero("rst held");
    reset_n = 1'b1;
    repeat (12) step();
    check_all_zero("rst no done");
    run_frame(2);

    // 1025 zero-length frames from reset bring rot_base back to all-ones.
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    step();
    check_all_zero("wrap start");
    prog_len = '0;
    for (int i = 0; i < 1025; i++) begin
      frame_strobe = 1'b1;
      step();
      frame_strobe = 1'b0;
      repeat (P) step();
      if (i == 0)
        check("wrap first rot_base", 32'(rot_base), 32'(ROT_ON ? 10'h3FF : 10'h000));
    end
    check("wrap rot_base", 32'(rot_base), 32'(ROT_ON ? 10'h3FF : 10'h000));
    check("wrap frame_done", 32'(frame_done), 32'd1);
    check("wrap overrun", 32'(overrun), 32'd0);
    check("wrap rd_en", 32'(fetch_if.instr_rd_en), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dsp_sequencer.md
# dsp_sequencer

Frame-synchronous program sequencer for a DSP core. It waits for an audio sample-frame strobe, then issues one instruction-memory read per cycle for a programmed number of instructions. It then holds off for the core pipeline depth so the last writeback completes, pulses `frame_done`, and advances a rotating sample-address base used for circular delay-line addressing. It sits between the frame-clock/IO logic and the core's instruction fetch port, replacing the core's free-running PC.

## Interface
Parameters:
- `INSTR_ADDR_WIDTH`, default 10: instruction memory address width.
- `SAMPLE_ADDR_WIDTH`, default 10: width of the rotation base.
- `PIPE_DEPTH`, default 4: fetch-to-writeback cycles to drain after the last fetch; legal range 1..15.

Ports:
- `clk`, in, 1: core clock; all state updates on the rising edge.
- `reset_n`, in, 1: asynchronous active-low reset.
- `frame_strobe`, in, 1: single-cycle pulse, one per sample frame.
- `prog_len`, in, `INSTR_ADDR_WIDTH`: instructions per frame; sampled only when a frame is accepted.
- `overrun_clr`, in, 1: clears the sticky `overrun` flag.
- `instr_rd_addr`, out, `INSTR_ADDR_WIDTH`: instruction address (PC).
- `instr_rd_en`, out, 1: a fetch is issued this cycle; downstream treats it as the instruction-valid seed.
- `rot_base`, out, `SAMPLE_ADDR_WIDTH`: rotation offset added to sample addresses by the core.
- `busy`, out, 1: high in FETCH and DRAIN.
- `frame_done`, out, 1: one-cycle pulse when a frame's program has fully retired.
- `overrun`, out, 1: sticky; a strobe arrived while busy.

## Operation
- The state machine has three states: `IDLE`, `FETCH` and `DRAIN`. It resets to `IDLE`.
- **IDLE:** on `frame_strobe`, latch `len = prog_len` and clear the PC.
  - If `len != 0`, go to `FETCH`.
  - If `len == 0`, go to `DRAIN` with no fetch issued.
- **FETCH:** `instr_rd_en = 1` and `instr_rd_addr = PC`, then PC increments.
  - In the cycle where `PC == len-1`, load `drain_cnt = PIPE_DEPTH-1` and go to `DRAIN`.
  - `prog_len = 2^INSTR_ADDR_WIDTH - 1` is the maximum; the PC never wraps inside a frame.
- **DRAIN:** `instr_rd_en = 0`, and `drain_cnt` decrements each cycle.
  - At `drain_cnt == 0`, go to `IDLE`, pulse `frame_done` in the following cycle, and update `rot_base`.
- **rot_base:** updated as `rot_base - 1` modulo `2^SAMPLE_ADDR_WIDTH`, so it wraps 0 -> all-ones. It changes only in the `frame_done` cycle, never mid-program.
- **Strobe while busy:** a `frame_strobe` in `FETCH` or `DRAIN` is dropped and sets `overrun`. The frame in progress is unaffected.
- **Overrun set vs. clear:** if `overrun_clr` and an overrun set occur in the same cycle, the set wins.
- **Strobe on the `frame_done` cycle:** accepted, because the state is already `IDLE`.
- **prog_len changes:** changes while busy have no effect until the next accepted strobe.
- **Reset values:** all outputs are 0. PC, `len`, `drain_cnt` and `rot_base` are 0, and the state is `IDLE`. Assertion of `reset_n` mid-frame aborts the frame immediately with no `frame_done`.

## Timing
- A strobe sampled at edge of cycle 0 with `len = N` produces fetches in cycles 1..N with addresses 0..N-1.
- DRAIN occupies cycles N+1..N+PIPE_DEPTH.
- `frame_done` and the new `rot_base` appear in cycle N+PIPE_DEPTH+1.
- `busy` is high in cycles 1..N+PIPE_DEPTH.
- With `len = 0`, `busy` is high in cycles 1..PIPE_DEPTH and `frame_done` is in cycle PIPE_DEPTH+1.
- Minimum strobe period without overrun is N+PIPE_DEPTH+1 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `DSP_SEQ_ROTATE_EN` defined: the `rot_base` register exists and decrements once per completed frame as described above.
- `DSP_SEQ_ROTATE_EN` undefined: `rot_base` is tied to 0, no register is synthesized, and all other behaviour is identical.

## Structure
- The shared package `dsp_pkg` holds:
  - `seq_state_t`, an enum with explicit encoding: `IDLE = 2'd0`, `FETCH = 2'd1`, `DRAIN = 2'd2`;
  - `opcode_t`, `instr_t`, and the default address-width constants shared with the core.
- `drain_cnt` is 4 bits wide, set by the `PIPE_DEPTH` range limit.
- Single flat module. The state machine and counters are small, so no sub-module is warranted.

## Test plan
- **Basic frame:** `PIPE_DEPTH = 4`, `prog_len = 3`, strobe at cycle 0 -> `instr_rd_addr` 0,1,2 with `instr_rd_en` in cycles 1-3; `busy` in cycles 1-7; `frame_done` in cycle 8 only; `rot_base` 0 -> 0x3FF at cycle 8.
- **Zero length:** `prog_len = 0`, strobe -> no `instr_rd_en` ever; `frame_done` in cycle 5; `rot_base` decrements.
- **Overrun:** `prog_len = 8`, second strobe at cycle 4 -> fetches 0..7 unaffected; `overrun = 1` from cycle 5. Then `overrun_clr` together with a new busy strobe -> `overrun` stays 1.
- **Back-to-back:** `prog_len = 2`, strobe at cycle 0 and again at cycle 7 (the `frame_done` cycle) -> second frame accepted, fetches in cycles 8-9, no overrun.
- **Reset mid-frame:** `prog_len = 10`, `reset_n` low at cycle 5 -> all outputs 0 asynchronously; no `frame_done`; a strobe after release starts a fresh frame at address 0.
- **Wrap and macro check:** 1025 frames with `DSP_SEQ_ROTATE_EN` -> `rot_base` returns to 0x3FF. With the macro undefined -> `rot_base` stays 0.
